// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a word-only data memory.
// Sub-word stores use a read-modify-write; loads extract and extend a lane.
module load_store_unit #(
    parameter int MEM_WORDS  = 256,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0]  SZ_B     = 2'b00;
    localparam logic [1:0]  SZ_H     = 2'b01;
    localparam logic [1:0]  SZ_W     = 2'b10;
    localparam logic [32:0] ADDR_LIM = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;   // store data, then the merged word in RMW_WR
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_err;
    logic [1:0]  lane;
    logic [4:0]  sh;
    logic [31:0] shifted, load_res, lane_mask, ins_mask, merged;

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_addr_o  = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};

    assign req_err = (req_size_i == 2'b11)
                   || (req_size_i == SZ_H && req_addr_i[0])
                   || (req_size_i == SZ_W && req_addr_i[1:0] != 2'b00)
                   || ({1'b0, req_addr_i} >= ADDR_LIM);

    // Lane index of the addressed byte/half inside the word (word accesses use lane 0)
    always_comb begin
        lane = 2'b00;
        if (size_q == SZ_B)
            lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
        else if (size_q == SZ_H)
            lane = BIG_ENDIAN ? {~addr_q[1], 1'b0} : {addr_q[1], 1'b0};
    end

    assign sh       = {lane, 3'b000};
    assign shifted  = mem_rdata_i >> sh;
    assign ins_mask = lane_mask << sh;
    assign merged   = (mem_rdata_i & ~ins_mask) | ((wdata_q & lane_mask) << sh);

    // Load extraction with sign/zero extension, and store lane mask
    always_comb begin
        load_res  = shifted;
        lane_mask = 32'hFFFF_FFFF;
        case (size_q)
            SZ_B: begin
                lane_mask = 32'h0000_00FF;
                load_res  = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                lane_mask = 32'h0000_FFFF;
                load_res  = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Next-state, latch and memory-strobe decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_wdata_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    write_d  = req_write_i;
                    wdata_d  = req_wdata_i;
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_write_i) begin
                        state_d = LOAD;
                    end else if (req_size_i == SZ_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_read_o  = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_res;
                state_d     = IDLE;
            end
            STORE: begin
                mem_write_o = 1'b1;
                mem_wdata_o = wdata_q;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            RMW_RD: begin
                mem_read_o = 1'b1;
                wdata_d    = merged;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                mem_write_o = 1'b1;
                mem_wdata_o = wdata_q;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers; reset aborts any transaction at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    int n_checks = 0, n_pass = 0;
    int n_rd = 0, n_wr = 0, n_rsp = 0, n_overlap = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256), .BIG_ENDIAN(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
        if (mem_read) n_rd++;
        if (mem_write) n_wr++;
        if (rsp_valid) n_rsp++;
    end

    always @(negedge clk) if (mem_read && mem_write) n_overlap++;

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
    endtask

    task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           output logic v, output logic [31:0] d, output logic e);
        @(negedge clk); drive(1'b0, sz, sg, a, 32'h0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); v = rsp_valid; d = rsp_rdata; e = rsp_err;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        n_checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_mem_rw got %b want 00", {mem_read, mem_write}); else n_pass++;
        n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata}); else n_pass++;
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_err, rsp_rdata}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_word;
        @(negedge clk); drive(1'b0, 2'b10, 1'b1, 32'h0, 32'h0);
        n_checks++; if (mem_read !== 1'b0) $display("FAIL lw_rd_T got %b want 0", mem_read); else n_pass++;
        @(negedge clk); req_valid = 1'b0;
        n_checks++; if ({req_ready, mem_read, mem_write, rsp_valid} !== 4'b0100) $display("FAIL lw_T1 got %b want 0100", {req_ready, mem_read, mem_write, rsp_valid}); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL lw_addr got %h want 0", mem_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err, mem_read, req_ready} !== 4'b1001) $display("FAIL lw_T2 got %b want 1001", {rsp_valid, rsp_err, mem_read, req_ready}); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0000000A) $display("FAIL lw_data got %h want 0000000a", rsp_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_rdata} !== 33'h0) $display("FAIL lw_T3 got %h want 0", {rsp_valid, rsp_rdata}); else n_pass++;
    endtask

    task automatic test_store_byte;
        logic v, e; logic [31:0] d;
        @(negedge clk); drive(1'b1, 2'b00, 1'b0, 32'h5, 32'h85);
        @(negedge clk); req_valid = 1'b0;
        n_checks++; if ({mem_read, mem_write, rsp_valid} !== 3'b100 || mem_addr !== 32'h4) $display("FAIL sb_T1 got %b/%h want 100/4", {mem_read, mem_write, rsp_valid}, mem_addr); else n_pass++;
        @(negedge clk);
        n_checks++; if ({mem_read, mem_write, rsp_valid} !== 3'b010) $display("FAIL sb_T2 got %b want 010", {mem_read, mem_write, rsp_valid}); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h00008501) $display("FAIL sb_wdata got %h want 00008501", mem_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) $display("FAIL sb_rsp got %h want 200000000", {rsp_valid, rsp_err, rsp_rdata}); else n_pass++;
        do_load(2'b00, 1'b1, 32'h5, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'hFFFFFF85}) $display("FAIL lb got %b%b %h want 10 ffffff85", v, e, d); else n_pass++;
        do_load(2'b00, 1'b0, 32'h5, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'h00000085}) $display("FAIL lbu got %b%b %h want 10 00000085", v, e, d); else n_pass++;
        do_load(2'b10, 1'b0, 32'h4, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'h00008501}) $display("FAIL lw4 got %b%b %h want 10 00008501", v, e, d); else n_pass++;
    endtask

    task automatic test_store_half;
        logic v, e; logic [31:0] d;
        @(negedge clk); drive(1'b1, 2'b01, 1'b0, 32'h12, 32'hBEEF);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'hBEEF0064) $display("FAIL sh_wdata got %b %h want 1 beef0064", mem_write, mem_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL sh_rsp got %b want 1", rsp_valid); else n_pass++;
        do_load(2'b01, 1'b1, 32'h12, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'hFFFFBEEF}) $display("FAIL lh got %b%b %h want 10 ffffbeef", v, e, d); else n_pass++;
        do_load(2'b01, 1'b0, 32'h12, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'h0000BEEF}) $display("FAIL lhu got %b%b %h want 10 0000beef", v, e, d); else n_pass++;
    endtask

    task automatic test_errors;
        logic        w  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h6, 32'h11, 32'h0, 32'h400};
        int rd0, wr0;
        for (int i = 0; i < 4; i++) begin
            rd0 = n_rd; wr0 = n_wr;
            @(negedge clk); drive(w[i], sz[i], 1'b1, ad[i], 32'h1234);
            @(negedge clk); req_valid = 1'b0;
            n_checks++; if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {3'b111, 32'h0}) $display("FAIL err%0d_rsp got %h want 700000000", i, {rsp_valid, rsp_err, req_ready, rsp_rdata}); else n_pass++;
            @(negedge clk);
            n_checks++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL err%0d_clear got %b want 00", i, {rsp_valid, rsp_err}); else n_pass++;
            n_checks++; if (n_rd !== rd0 || n_wr !== wr0) $display("FAIL err%0d_mem got rd+%0d wr+%0d want 0", i, n_rd - rd0, n_wr - wr0); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_T0 ready got %b want 1", req_ready); else n_pass++;
        @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        n_checks++; if ({req_ready, rsp_valid} !== 2'b00) $display("FAIL b2b_T1 got %b want 00", {req_ready, rsp_valid}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({req_ready, rsp_valid} !== 2'b11 || rsp_rdata !== 32'h0000000A) $display("FAIL b2b_T2 got %b %h want 11 0000000a", {req_ready, rsp_valid}, rsp_rdata); else n_pass++;
        @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_checks++; if ({req_ready, rsp_valid} !== 2'b00) $display("FAIL b2b_T3 got %b want 00", {req_ready, rsp_valid}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({req_ready, rsp_valid} !== 2'b11 || rsp_rdata !== 32'h00008501) $display("FAIL b2b_T4 got %b %h want 11 00008501", {req_ready, rsp_valid}, rsp_rdata); else n_pass++;
        @(negedge clk); req_valid = 1'b0;
        n_checks++; if ({req_ready, rsp_valid} !== 2'b00) $display("FAIL b2b_T5 got %b want 00", {req_ready, rsp_valid}); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF0064) $display("FAIL b2b_T6 got %b %h want 1 beef0064", rsp_valid, rsp_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL b2b_T7 got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int wr0, rsp0;
        logic v, e; logic [31:0] d;
        wr0 = n_wr; rsp0 = n_rsp;
        @(negedge clk); drive(1'b1, 2'b00, 1'b0, 32'h0, 32'hAA);
        @(negedge clk); req_valid = 1'b0;
        n_checks++; if (mem_read !== 1'b1) $display("FAIL rst_mid_rmwrd got %b want 1", mem_read); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_write, mem_read, req_ready} !== 3'b001) $display("FAIL rst_mid_async got %b want 001", {mem_write, mem_read, req_ready}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (n_wr !== wr0 || n_rsp !== rsp0) $display("FAIL rst_mid_quiet got wr+%0d rsp+%0d want 0", n_wr - wr0, n_rsp - rsp0); else n_pass++;
        do_load(2'b10, 1'b0, 32'h0, v, d, e);
        n_checks++; if ({v, e, d} !== {2'b10, 32'h0000000A}) $display("FAIL rst_mid_lw got %b%b %h want 10 0000000a", v, e, d); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'd10; mem[1] = 32'd1; mem[4] = 32'd100;
        test_reset;
        test_load_word;
        test_store_byte;
        test_store_half;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        n_checks++; if (n_overlap !== 0) $display("FAIL rd_wr_overlap got %0d want 0", n_overlap); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the word-only data memory.
- Turns byte, halfword and word loads and stores into word accesses; sub-word stores use a read-modify-write sequence.
- Performs load extraction with sign or zero extension, plus alignment and range checking.
- Holds off the pipeline with req_ready while a transaction is in flight.

Parameters:
MEM_WORDS, 256, number of 32-bit words in data memory; valid byte addresses are 0 .. MEM_WORDS*4-1
BIG_ENDIAN, 0, 0: byte at addr[1:0]=0 occupies bits [7:0]; 1: it occupies bits [31:24]

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage presents a request
req_ready  out  1  unit idle and able to accept; a request is accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle pulse when a transaction completes
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or illegal size
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite; the write occurs at the next clk edge
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}; 0 when idle
mem_wdata  out  32  to memory WriteData
mem_rdata  in  32  combinational read data from memory

Behaviour:
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
- req_ready = (state==IDLE).
- mem_* outputs are decoded from state and latched registers only, with no combinational path from req_*.
- Reset (async, rst_n low): state=IDLE, all latched registers 0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Hence req_ready=1, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Accept (cycle T): latch addr, size, signed, wdata and write flag. Error when any of the following holds:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr >= MEM_WORDS*4
- Error path: stay in IDLE, no memory access. At T+1: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Load: IDLE->LOAD at T.
  - T+1: mem_read=1; byte/half lane is selected from mem_rdata by addr[1:0] and BIG_ENDIAN, then extended per req_signed.
  - T+2: rsp_valid=1, rsp_rdata=result; state back in IDLE.
  - Total latency 2; a new request can be accepted at T+2.
- Word store: IDLE->STORE.
  - T+1: mem_write=1, mem_wdata=wdata.
  - T+2: rsp_valid=1; state IDLE.
- Sub-word store: IDLE->RMW_RD->RMW_WR->IDLE.
  - RMW_RD (T+1): mem_read=1; register the merged word, i.e. mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR (T+2): mem_write=1, mem_wdata=merged, mem_read=0.
  - T+3: rsp_valid=1.
- rsp_valid is high for exactly one cycle per accepted request. rsp_rdata and rsp_err return to 0 the cycle after.
- req_valid while busy is ignored; the request is neither latched nor dropped, and the MEM stage must hold it.
- Reset mid-transaction: returns to IDLE immediately. mem_write deasserts combinationally, so no memory write occurs at any edge while rst_n=0. No rsp_valid is produced for the aborted request.
- Never assert mem_read and mem_write in the same cycle.

Test Plan:
- Memory words 0=10, 1=1, 4=100. lw 0x0 (size 10, signed 1) -> rsp_valid at T+2, rsp_rdata=0x0000000A, rsp_err=0; mem_read high exactly one cycle.
- sb 0x85 to 0x5 (BIG_ENDIAN=0) -> mem_read at T+1, mem_write at T+2 with mem_wdata=0x00008501, rsp_valid at T+3. Then:
  - lb 0x5 (signed 1) -> 0xFFFFFF85
  - lbu 0x5 -> 0x00000085
  - lw 0x4 -> 0x00008501
- sh 0xBEEF to 0x12 -> word 4 becomes 0xBEEF0064. Then:
  - lh 0x12 -> 0xFFFFBEEF
  - lhu 0x12 -> 0x0000BEEF
- Errors: lw 0x6, sh 0x11, size=11, and lw 0x400 with MEM_WORDS=256 -> each gives rsp_valid at T+1 with rsp_err=1 and rsp_rdata=0; mem_read and mem_write stay 0 throughout.
- Back-to-back: req_valid held high with 3 loads -> accepted at T, T+2, T+4; req_ready low in T+1 and T+3; responses at T+2, T+4, T+6.
- Reset asserted during RMW_RD of sb 0xAA to 0x0 -> mem_write never asserted, no rsp_valid. After release, lw 0x0 returns 0x0000000A.
